pipe_hazard_unit: RTL and testbench

- Hazard and forwarding controller for the five-stage pipeline (fetch, decode, execute, memory, writeback).
- Generalises the un-interlocked pipeline: adds data forwarding, load-use interlock, branch flush, a no-forwarding interlock mode, and saturating performance counters.
- Keeps its own shadow copy of in-flight register usage (EX/M/W slots), so the datapath only supplies decode-stage fields and the execute-stage branch decision.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/sat_counter.sv | 34 +++
 rtl/pipe_hazard_unit.sv | 113 +++++++++++
 tb/tb_pipe_hazard_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard unit: forwarding select codes and the
// shadow-slot record that tracks each in-flight instruction's register usage.
package pipe_pkg;

    // Slot register fields are stored at this fixed width; narrower indices are zero-extended.
    localparam int unsigned SLOT_AW = 8;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef struct packed {
        logic               v;
        logic [SLOT_AW-1:0] rs1;
        logic [SLOT_AW-1:0] rs2;
        logic [SLOT_AW-1:0] rd;
        logic               rw;
        logic               ld;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    // x0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic slot_writes(input slot_t s, input logic [SLOT_AW-1:0] r);
        return s.v & s.rw & (s.rd == r) & (r != '0);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for a five-stage pipeline; shadows EX/M/W register
// usage internally and derives forwarding selects, stalls, flushes and perf counts.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_load,
    input  logic              ex_branch_taken,
    input  logic              cnt_clr,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    slot_t              ex_q, m_q, w_q;
    slot_t              ex_d;
    slot_t              id_slot;
    logic [SLOT_AW-1:0] rs1_w, rs2_w;
    logic               haz;
    logic               br;

    function automatic logic [1:0] fwd_sel(input slot_t m, input slot_t w,
                                           input logic [SLOT_AW-1:0] r);
        if (slot_writes(m, r)) begin
            return FWD_M;
        end else if (slot_writes(w, r)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    assign rs1_w = SLOT_AW'(id_rs1);
    assign rs2_w = SLOT_AW'(id_rs2);

    always_comb begin
        id_slot     = SLOT_EMPTY;
        id_slot.v   = id_valid;
        id_slot.rs1 = rs1_w;
        id_slot.rs2 = rs2_w;
        id_slot.rd  = SLOT_AW'(id_rd);
        id_slot.rw  = id_regwrite;
        id_slot.ld  = id_load;
    end

    // Without forwarding, any EX/M producer blocks decode; W is covered by write-first regfile.
    always_comb begin
        haz = 1'b0;
        if (id_valid) begin
            if (FWD_EN) begin
                haz = ex_q.ld & (slot_writes(ex_q, rs1_w) | slot_writes(ex_q, rs2_w));
            end else begin
                haz = slot_writes(ex_q, rs1_w) | slot_writes(ex_q, rs2_w)
                    | slot_writes(m_q, rs1_w)  | slot_writes(m_q, rs2_w);
            end
        end
    end

    // The branch input is raw from execute; mask it so every output is quiet in reset.
    assign br      = ex_branch_taken & ~rst;
    assign stall_f = haz & ~br;
    assign stall_d = haz & ~br;
    assign flush_d = br;
    assign flush_e = br | haz;

    assign fwd_a_e = (FWD_EN && ex_q.v) ? fwd_sel(m_q, w_q, ex_q.rs1) : FWD_RF;
    assign fwd_b_e = (FWD_EN && ex_q.v) ? fwd_sel(m_q, w_q, ex_q.rs2) : FWD_RF;

    assign ex_d = flush_e ? SLOT_EMPTY : id_slot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= SLOT_EMPTY;
            m_q  <= SLOT_EMPTY;
            w_q  <= SLOT_EMPTY;
        end else begin
            ex_q <= ex_d;
            m_q  <= ex_q;
            w_q  <= m_q;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_d),
        .clr (cnt_clr),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (br),
        .clr (cnt_clr),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: three configurations driven by one stimulus stream,
// each checked every cycle against an instruction-history model plus literal checks.
module tb_pipe_hazard_unit;

    localparam int unsigned AW = 5;
    localparam int unsigned NC = 3;
    localparam int FWD_C[NC] = '{1, 0, 1};
    localparam int CMAX[NC]  = '{65535, 65535, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          id_valid = 1'b0, id_regwrite = 1'b0, id_load = 1'b0;
    logic          ex_branch_taken = 1'b0, cnt_clr = 1'b0;
    logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;

    logic [NC-1:0][1:0] fa, fb;
    logic [NC-1:0]      sf, sd, fd, fe;
    logic [15:0]        sc0, fc0, sc1, fc1;
    logic [1:0]         sc2, fc2;

    pipe_hazard_unit #(.REG_AW(AW), .FWD_EN(1'b1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_load(id_load),
        .ex_branch_taken(ex_branch_taken), .cnt_clr(cnt_clr),
        .fwd_a_e(fa[0]), .fwd_b_e(fb[0]), .stall_f(sf[0]), .stall_d(sd[0]),
        .flush_d(fd[0]), .flush_e(fe[0]), .stall_cnt(sc0), .flush_cnt(fc0));

    pipe_hazard_unit #(.REG_AW(AW), .FWD_EN(1'b0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_load(id_load),
        .ex_branch_taken(ex_branch_taken), .cnt_clr(cnt_clr),
        .fwd_a_e(fa[1]), .fwd_b_e(fb[1]), .stall_f(sf[1]), .stall_d(sd[1]),
        .flush_d(fd[1]), .flush_e(fe[1]), .stall_cnt(sc1), .flush_cnt(fc1));

    pipe_hazard_unit #(.REG_AW(AW), .FWD_EN(1'b1), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_load(id_load),
        .ex_branch_taken(ex_branch_taken), .cnt_clr(cnt_clr),
        .fwd_a_e(fa[2]), .fwd_b_e(fb[2]), .stall_f(sf[2]), .stall_d(sd[2]),
        .flush_d(fd[2]), .flush_e(fe[2]), .stall_cnt(sc2), .flush_cnt(fc2));

    typedef struct {
        bit v;
        int rs1, rs2, rd;
        bit rw, ld;
    } rec_t;

    // hist[c][age]: the instruction that entered execute `age` cycles ago (0 = EX, 1 = M, 2 = W)
    rec_t hist[NC][3];
    int   scnt[NC], fcnt[NC];
    bit   exp_stall[NC], exp_fe[NC];
    rec_t last_id;
    bit   last_br, last_clr, last_rst = 1'b1;

    int total = 0;
    int bad   = 0;

    function automatic bit writes(rec_t s, int r);
        return s.v && s.rw && (s.rd == r) && (r != 0);
    endfunction

    function automatic int src_sel(rec_t m, rec_t w, int r);
        if (writes(m, r)) return 2;
        if (writes(w, r)) return 1;
        return 0;
    endfunction

    task automatic chk(string nm, int c, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cfg%0d: got %0d want %0d at %0t", nm, c, act, exp, $time);
        end
    endtask

    task automatic lit(string nm, logic [31:0] act, logic [31:0] exp);
        chk(nm, 9, act, exp);
    endtask

    task automatic clear_model();
        rec_t z;
        z = '{default: 0};
        for (int c = 0; c < NC; c++) begin
            for (int a = 0; a < 3; a++) hist[c][a] = z;
            scnt[c] = 0;
            fcnt[c] = 0;
        end
    endtask

    task automatic advance();
        rec_t z;
        z = '{default: 0};
        if (last_rst) begin
            clear_model();
            return;
        end
        for (int c = 0; c < NC; c++) begin
            if (last_clr) begin
                scnt[c] = 0;
                fcnt[c] = 0;
            end else begin
                if (exp_stall[c] && scnt[c] < CMAX[c]) scnt[c]++;
                if (last_br && fcnt[c] < CMAX[c]) fcnt[c]++;
            end
            hist[c][2] = hist[c][1];
            hist[c][1] = hist[c][0];
            hist[c][0] = exp_fe[c] ? z : last_id;
        end
    endtask

    task automatic check_all();
        rec_t id, ex, m, w;
        bit   haz, st, fdx;
        int   ea, eb;
        logic [31:0] asc, afc;
        id = '{v: id_valid, rs1: int'(id_rs1), rs2: int'(id_rs2), rd: int'(id_rd),
               rw: id_regwrite, ld: id_load};
        for (int c = 0; c < NC; c++) begin
            ex = hist[c][0];
            m  = hist[c][1];
            w  = hist[c][2];
            if (FWD_C[c] == 1)
                haz = id.v && ex.ld && (writes(ex, id.rs1) || writes(ex, id.rs2));
            else
                haz = id.v && (writes(ex, id.rs1) || writes(ex, id.rs2) ||
                               writes(m, id.rs1)  || writes(m, id.rs2));
            fdx = ex_branch_taken && !rst;
            if (rst) haz = 1'b0;
            st = haz && !fdx;
            ea = (FWD_C[c] == 1 && ex.v) ? src_sel(m, w, ex.rs1) : 0;
            eb = (FWD_C[c] == 1 && ex.v) ? src_sel(m, w, ex.rs2) : 0;
            case (c)
                0:       begin asc = 32'(sc0); afc = 32'(fc0); end
                1:       begin asc = 32'(sc1); afc = 32'(fc1); end
                default: begin asc = 32'(sc2); afc = 32'(fc2); end
            endcase
            chk("fwd_a_e",   c, 32'(fa[c]), 32'(ea));
            chk("fwd_b_e",   c, 32'(fb[c]), 32'(eb));
            chk("stall_f",   c, 32'(sf[c]), 32'(st));
            chk("stall_d",   c, 32'(sd[c]), 32'(st));
            chk("flush_d",   c, 32'(fd[c]), 32'(fdx));
            chk("flush_e",   c, 32'(fe[c]), 32'(fdx || haz));
            chk("stall_cnt", c, asc, 32'(scnt[c]));
            chk("flush_cnt", c, afc, 32'(fcnt[c]));
            exp_stall[c] = st;
            exp_fe[c]    = fdx || haz;
        end
        last_id  = id;
        last_br  = ex_branch_taken;
        last_clr = cnt_clr;
        last_rst = rst;
    endtask

    // One cycle: retire the previous cycle into the model, drive new inputs, compare mid-cycle.
    task automatic step(bit v, int r1, int r2, int rd, bit rw, bit ld, bit br, bit clr, bit r);
        @(posedge clk);
        advance();
        #1;
        rst             = r;
        id_valid        = v;
        id_rs1          = AW'(r1);
        id_rs2          = AW'(r2);
        id_rd           = AW'(rd);
        id_regwrite     = rw;
        id_load         = ld;
        ex_branch_taken = br;
        cnt_clr         = clr;
        if (r) clear_model();
        #4;
        check_all();
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_rst();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        clear_model();
        do_rst();
        lit("reset_stall_d", 32'(sd[0]), 0);
        lit("reset_fwd_a", 32'(fa[0]), 0);
        lit("reset_stall_cnt", 32'(sc0), 0);

        // ALU result forwarded from M to the immediately dependent instruction
        step(1, 1, 2, 5, 1, 0, 0, 0, 0);
        step(1, 5, 1, 6, 1, 0, 0, 0, 0);
        lit("addsub_no_stall", 32'(sd[0]), 0);
        nop();
        lit("addsub_fwd_a_M", 32'(fa[0]), 2);
        lit("addsub_stall_cnt", 32'(sc0), 0);

        do_rst();
        step(1, 1, 2, 5, 1, 0, 0, 0, 0);
        nop();
        step(1, 1, 5, 7, 1, 0, 0, 0, 0);
        nop();
        lit("and_fwd_b_W", 32'(fb[0]), 1);

        do_rst();
        step(1, 1, 2, 5, 1, 0, 0, 0, 0);
        step(1, 3, 4, 5, 1, 0, 0, 0, 0);
        step(1, 1, 5, 7, 1, 0, 0, 0, 0);
        nop();
        lit("and_fwd_b_M_wins", 32'(fb[0]), 2);

        // Load-use: one bubble, then forwarding from W
        do_rst();
        step(1, 1, 0, 5, 1, 1, 0, 0, 0);
        step(1, 5, 5, 6, 1, 0, 0, 0, 0);
        lit("lu_stall_f", 32'(sf[0]), 1);
        lit("lu_stall_d", 32'(sd[0]), 1);
        lit("lu_flush_e", 32'(fe[0]), 1);
        step(1, 5, 5, 6, 1, 0, 0, 0, 0);
        lit("lu_released", 32'(sd[0]), 0);
        lit("lu_stall_cnt", 32'(sc0), 1);
        nop();
        lit("lu_fwd_a_W", 32'(fa[0]), 1);
        lit("lu_fwd_b_W", 32'(fb[0]), 1);

        do_rst();
        step(1, 1, 0, 5, 1, 1, 0, 0, 0);
        step(1, 5, 0, 6, 1, 0, 1, 0, 0);
        lit("br_flush_d", 32'(fd[0]), 1);
        lit("br_flush_e", 32'(fe[0]), 1);
        lit("br_no_stall", 32'(sd[0]), 0);
        nop();
        lit("br_flush_cnt", 32'(fc0), 1);
        lit("br_stall_cnt", 32'(sc0), 0);

        // No-forwarding build: back-to-back RAW holds decode for two cycles
        do_rst();
        step(1, 1, 2, 5, 1, 0, 0, 0, 0);
        step(1, 5, 1, 6, 1, 0, 0, 0, 0);
        lit("nf_stall1", 32'(sd[1]), 1);
        step(1, 5, 1, 6, 1, 0, 0, 0, 0);
        lit("nf_stall2", 32'(sd[1]), 1);
        step(1, 5, 1, 6, 1, 0, 0, 0, 0);
        lit("nf_released", 32'(sd[1]), 0);
        lit("nf_stall_cnt", 32'(sc1), 2);
        lit("nf_fwd_a", 32'(fa[1]), 0);
        do_rst();
        step(1, 1, 2, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 6, 1, 0, 0, 0, 0);
        lit("nf_x0_no_stall", 32'(sd[1]), 0);

        // Five load-use stalls saturate the 2-bit counter
        do_rst();
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 5, 1, 1, 0, 0, 0);
            step(1, 5, 0, 6, 1, 0, 0, 0, 0);
        end
        nop();
        lit("sat_cnt2", 32'(sc2), 3);
        lit("sat_cnt16", 32'(sc0), 5);
        step(1, 1, 0, 5, 1, 1, 0, 0, 0);
        step(1, 5, 0, 6, 1, 0, 0, 1, 0);
        lit("clr_during_stall", 32'(sd[0]), 1);
        nop();
        lit("clr_cnt2", 32'(sc2), 0);
        lit("clr_cnt16", 32'(sc0), 0);

        // Reset during a load-use stall
        step(1, 1, 0, 5, 1, 1, 0, 0, 0);
        step(1, 5, 0, 6, 1, 0, 0, 0, 1);
        lit("rst_mid_stall", 32'(sd[0]), 0);
        step(1, 5, 0, 6, 1, 0, 0, 0, 0);
        lit("rst_after_release", 32'(sd[0]), 0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) < 85,
                 int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom_range(7)),
                 $urandom_range(99) < 70, $urandom_range(99) < 30,
                 $urandom_range(99) < 10, $urandom_range(99) < 3,
                 $urandom_range(999) < 8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
